// File: rtl/cmem_dbuf.sv
// cmem_dbuf: double-buffered, multi-channel filter coefficient memory.
// A shadow bank is loaded bit-serially while NCH read ports see the active
// bank; a swap request exchanges the banks once the shadow is fully loaded.
// Ports:
//   clk, rst_n    clock (rising edge), async active-low reset
//   sde_in, sd_in serial shift enable / serial data into shadow LSB
//   sd_out        shadow MSB (combinational), chains to next device
//   swap_in       swap request; accepted when full_out=1 and sde_in=0
//   addr_in       NCH read addresses, channel k in slice k
//   d_out         NCH registered read words, channel k in slice k
//   full_out      shadow holds a complete new coefficient set
//   swap_err_out  one-cycle pulse after a rejected swap request
module cmem_dbuf #(
  parameter int unsigned DATABITS = 16,
  parameter int unsigned CMEMSIZE = 32,
  parameter int unsigned NCH      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sde_in,
  input  logic                            sd_in,
  output logic                            sd_out,
  input  logic                            swap_in,
  input  logic [NCH*$clog2(CMEMSIZE)-1:0] addr_in,
  output logic [NCH*DATABITS-1:0]         d_out,
  output logic                            full_out,
  output logic                            swap_err_out
);

  localparam int unsigned AW  = $clog2(CMEMSIZE);
  localparam int unsigned TOT = DATABITS * CMEMSIZE;
  localparam int unsigned CW  = $clog2(TOT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TOT);

  logic [TOT-1:0]          bank0;
  logic [TOT-1:0]          bank1;
  logic                    sel;
  logic [CW-1:0]           cnt;
  logic [TOT-1:0]          active_c;
  logic [TOT-1:0]          shadow_c;
  logic                    swap_ok_c;
  logic [NCH*DATABITS-1:0] rd_c;

  // Bank routing: sel names the active bank, the other one is the shadow.
  assign active_c  = sel ? bank1 : bank0;
  assign shadow_c  = sel ? bank0 : bank1;
  assign sd_out    = shadow_c[TOT-1];
  assign swap_ok_c = swap_in & full_out & ~sde_in;

  // Per-channel word select; addresses beyond the last word read as zero.
  always_comb begin
    rd_c = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      for (int unsigned w = 0; w < CMEMSIZE; w++) begin
        if (addr_in[k*AW +: AW] == AW'(w)) begin
          rd_c[k*DATABITS +: DATABITS] = active_c[w*DATABITS +: DATABITS];
        end
      end
    end
  end

  // Shadow loading, fill counter, bank swap and registered reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0        <= '0;
      bank1        <= '0;
      sel          <= 1'b0;
      cnt          <= '0;
      full_out     <= 1'b0;
      swap_err_out <= 1'b0;
      d_out        <= '0;
    end else begin
      if (sde_in) begin
        if (sel) begin
          bank0 <= {bank0[TOT-2:0], sd_in};
        end else begin
          bank1 <= {bank1[TOT-2:0], sd_in};
        end
        // Counter saturates; shifting past full just streams data through.
        if (cnt != CNT_MAX) begin
          cnt      <= cnt + CW'(1);
          full_out <= ((cnt + CW'(1)) == CNT_MAX);
        end
      end else if (swap_ok_c) begin
        sel      <= ~sel;
        cnt      <= '0;
        full_out <= 1'b0;
      end
      swap_err_out <= swap_in & ~swap_ok_c;
      // Reads on the swap edge still use the old sel, i.e. the old bank.
      d_out <= rd_c;
    end
  end

endmodule

// File: tb/tb_cmem_dbuf.sv
module tb_cmem_dbuf;

  localparam int DB  = 8;
  localparam int CM  = 4;
  localparam int TOT = DB * CM;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sde_in, sd_in, swap_in, sd_out, full_out, swap_err_out;
  logic [3:0]  addr_in;
  logic [15:0] d_out;

  logic        sde3, sd3, swap3, sdo3, full3, err3;
  logic [3:0]  addr3;
  logic [15:0] d3;

  int n_chk = 0;
  int n_fail = 0;

  cmem_dbuf #(.DATABITS(8), .CMEMSIZE(4), .NCH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .sde_in(sde_in), .sd_in(sd_in), .sd_out(sd_out),
    .swap_in(swap_in), .addr_in(addr_in), .d_out(d_out), .full_out(full_out),
    .swap_err_out(swap_err_out)
  );

  cmem_dbuf #(.DATABITS(8), .CMEMSIZE(3), .NCH(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sde_in(sde3), .sd_in(sd3), .sd_out(sdo3),
    .swap_in(swap3), .addr_in(addr3), .d_out(d3), .full_out(full3),
    .swap_err_out(err3)
  );

  always #5 clk = ~clk;

  // Reference model: each bank is a bit queue in arrival order (front = oldest bit).
  bit          q0[$];
  bit          q1[$];
  bit          m_sel;
  int          m_cnt;
  bit          m_full, m_err;
  logic [15:0] m_dout;

  logic [7:0] set1 [4] = '{8'hA3, 8'h5C, 8'h0F, 8'hF0};
  logic [7:0] set2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  function automatic logic [7:0] mword(bit b, int a);
    logic [7:0] w = 8'h00;
    if (a >= CM) return 8'h00;
    for (int j = 0; j < DB; j++)
      w[DB-1-j] = b ? q1[(CM-1-a)*DB + j] : q0[(CM-1-a)*DB + j];
    return w;
  endfunction

  function automatic bit m_sdo();
    return m_sel ? q0[0] : q1[0];
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int i = 0; i < TOT; i++) begin q0.push_back(1'b0); q1.push_back(1'b0); end
    m_sel = 1'b0; m_cnt = 0; m_full = 1'b0; m_err = 1'b0; m_dout = 16'h0;
  endtask

  // Advance model by one edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit acc;
    logic [15:0] nd;
    acc = swap_in && m_full && !sde_in;
    for (int k = 0; k < 2; k++) nd[k*8 +: 8] = mword(m_sel, int'(addr_in[k*2 +: 2]));
    if (sde_in) begin
      if (m_sel) begin q0.push_back(sd_in); void'(q0.pop_front()); end
      else       begin q1.push_back(sd_in); void'(q1.pop_front()); end
      if (m_cnt < TOT) m_cnt++;
    end
    if (acc) begin m_sel = !m_sel; m_cnt = 0; end
    m_full = (m_cnt == TOT);
    m_err  = swap_in && !acc;
    m_dout = nd;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sde_in = 0; sd_in = 0; swap_in = 0; addr_in = '0;
    sde3 = 0; sd3 = 0; swap3 = 0; addr3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic shift_word(logic [7:0] w);
    for (int j = 7; j >= 0; j--) begin
      sde_in = 1'b1; sd_in = w[j]; tick();
    end
    sde_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (d_out !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", d_out); end
    n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full_out); end
    n_chk++; if (sd_out !== 1'b0) begin n_fail++; $display("FAIL reset_sdout: got %b expected 0", sd_out); end
    n_chk++; if (swap_err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", swap_err_out); end
    for (int a = 0; a < 4; a++) begin
      addr_in = {2'(a), 2'(3 - a)}; tick();
      n_chk++; if (d_out !== 16'h0 || d_out !== m_dout) begin n_fail++; $display("FAIL reset_read a=%0d: got %h expected 0000", a, d_out); end
    end
  endtask

  task automatic test_load_swap();
    int b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 7; j >= 0; j--) begin
        sde_in = 1'b1; sd_in = set1[i][j]; tick(); b++;
        if (b == 31) begin n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b expected 0", full_out); end end
        if (b == 32) begin n_chk++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL full_32: got %b expected 1", full_out); end end
      end
    sde_in = 1'b0;
    swap_in = 1'b1; addr_in = {2'd3, 2'd0}; tick(); swap_in = 1'b0;
    n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL full_after_swap: got %b expected 0", full_out); end
    n_chk++; if (d_out !== m_dout) begin n_fail++; $display("FAIL swap_edge_read: got %h expected %h", d_out, m_dout); end
    tick();
    n_chk++; if (d_out !== 16'hA3F0) begin n_fail++; $display("FAIL new_set_read: got %h expected a3f0", d_out); end
    n_chk++; if (sd_out !== 1'b0) begin n_fail++; $display("FAIL readback_zero: got %b expected 0", sd_out); end
  endtask

  task automatic test_swap_reject();
    for (int i = 0; i < 20; i++) begin sde_in = 1'b1; sd_in = 1'($urandom); tick(); end
    sde_in = 1'b0; swap_in = 1'b1; addr_in = {2'd3, 2'd0}; tick(); swap_in = 1'b0;
    n_chk++; if (swap_err_out !== 1'b1) begin n_fail++; $display("FAIL reject_err: got %b expected 1", swap_err_out); end
    n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reject_full: got %b expected 0", full_out); end
    tick();
    n_chk++; if (swap_err_out !== 1'b0) begin n_fail++; $display("FAIL reject_err_pulse: got %b expected 0", swap_err_out); end
    n_chk++; if (d_out !== 16'hA3F0) begin n_fail++; $display("FAIL reject_keep_set: got %h expected a3f0", d_out); end
  endtask

  task automatic test_shift_priority();
    for (int i = 0; i < 12; i++) begin sde_in = 1'b1; sd_in = 1'($urandom); tick(); end
    n_chk++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL refill_full: got %b expected 1", full_out); end
    sde_in = 1'b1; swap_in = 1'b1; sd_in = 1'($urandom); tick(); sde_in = 1'b0; swap_in = 1'b0;
    n_chk++; if (swap_err_out !== 1'b1) begin n_fail++; $display("FAIL prio_err: got %b expected 1", swap_err_out); end
    n_chk++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL prio_full: got %b expected 1", full_out); end
    n_chk++; if (sd_out !== m_sdo()) begin n_fail++; $display("FAIL prio_sdout: got %b expected %b", sd_out, m_sdo()); end
    addr_in = {2'd3, 2'd0}; tick(); tick();
    n_chk++; if (d_out !== 16'hA3F0) begin n_fail++; $display("FAIL prio_keep_set: got %h expected a3f0", d_out); end
  endtask

  task automatic test_second_set();
    for (int i = 0; i < 4; i++) shift_word(set2[i]);
    n_chk++; if (full_out !== 1'b1) begin n_fail++; $display("FAIL set2_full: got %b expected 1", full_out); end
    swap_in = 1'b1; tick(); swap_in = 1'b0; tick();
    n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL set2_swap_full: got %b expected 0", full_out); end
    for (int i = 0; i < 32; i++) begin
      n_chk++; if (sd_out !== set1[i/8][7 - i%8]) begin n_fail++; $display("FAIL readback bit %0d: got %b expected %b", i, sd_out, set1[i/8][7 - i%8]); end
      sde_in = 1'b1; sd_in = 1'($urandom); tick();
    end
    sde_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int a0, a1;
      a0 = $urandom_range(0, 3); a1 = $urandom_range(0, 3);
      addr_in = {2'(a1), 2'(a0)}; tick();
      n_chk++; if (d_out !== {set2[3 - a1], set2[3 - a0]}) begin n_fail++; $display("FAIL set2_read %0d/%0d: got %h expected %h", a1, a0, d_out, {set2[3 - a1], set2[3 - a0]}); end
    end
    addr_in = {2'd3, 2'd3}; tick();
    n_chk++; if (d_out !== 16'h1111) begin n_fail++; $display("FAIL same_addr: got %h expected 1111", d_out); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 17; i++) begin sde_in = 1'b1; sd_in = 1'($urandom); tick(); end
    addr_in = {2'd3, 2'd0};
    #2 rst_n = 1'b0; sde_in = 1'b0;
    model_reset();
    #1;
    n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got %b expected 0", full_out); end
    n_chk++; if (d_out !== 16'h0) begin n_fail++; $display("FAIL midrst_dout: got %h expected 0000", d_out); end
    n_chk++; if (sd_out !== 1'b0) begin n_fail++; $display("FAIL midrst_sdout: got %b expected 0", sd_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr_in = {2'(a), 2'(a)}; tick();
      n_chk++; if (d_out !== 16'h0 || d_out !== m_dout) begin n_fail++; $display("FAIL midrst_read a=%0d: got %h expected 0000", a, d_out); end
    end
    n_chk++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL midrst_full2: got %b expected 0", full_out); end
  endtask

  task automatic test_cmem3();
    logic [7:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom_range(1, 255));
    for (int i = 2; i >= 0; i--)
      for (int j = 7; j >= 0; j--) begin sde3 = 1'b1; sd3 = w[i][j]; tick(); end
    sde3 = 1'b0;
    n_chk++; if (full3 !== 1'b1) begin n_fail++; $display("FAIL c3_full: got %b expected 1", full3); end
    swap3 = 1'b1; addr3 = {2'd3, 2'd0}; tick(); swap3 = 1'b0; tick();
    n_chk++; if (d3 !== {8'h00, w[0]}) begin n_fail++; $display("FAIL c3_addr3: got %h expected %h", d3, {8'h00, w[0]}); end
    addr3 = {2'd2, 2'd3}; tick();
    n_chk++; if (d3 !== {w[2], 8'h00}) begin n_fail++; $display("FAIL c3_addr2: got %h expected %h", d3, {w[2], 8'h00}); end
    n_chk++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL c3_err: got %b expected 0", err3); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      sde_in  = ($urandom_range(0, 9) < 7);
      sd_in   = 1'($urandom);
      swap_in = ($urandom_range(0, 7) == 0);
      addr_in = 4'($urandom);
      tick();
      n_chk++; if (d_out !== m_dout) begin n_fail++; $display("FAIL rnd_dout c=%0d: got %h expected %h", c, d_out, m_dout); end
      n_chk++; if (full_out !== m_full) begin n_fail++; $display("FAIL rnd_full c=%0d: got %b expected %b", c, full_out, m_full); end
      n_chk++; if (swap_err_out !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d: got %b expected %b", c, swap_err_out, m_err); end
      n_chk++; if (sd_out !== m_sdo()) begin n_fail++; $display("FAIL rnd_sdout c=%0d: got %b expected %b", c, sd_out, m_sdo()); end
    end
    sde_in = 1'b0; swap_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_swap_reject();
    test_shift_priority();
    test_second_set();
    test_cmem3();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
